// File: rtl/game_judge_ctrl.sv
// game_judge_ctrl: sequential tic-tac-toe judge. It walks a 9:1 cell mux to
// capture the board, then checks one of the eight lines per cycle. It reports
// the winner, a draw, or an illegal board after a fixed 18-cycle latency.
module game_judge_ctrl #(
  parameter logic [15:0] P1_CODE = 16'd1,
  parameter logic [15:0] P2_CODE = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cell_data,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic [2:0]  win_line,
  output logic        draw,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [2:0]  chk_q, chk_d;        // line index under evaluation in CHECK
  logic [8:0]  p1_q, p1_d;          // per-cell occupancy masks
  logic [8:0]  p2_q, p2_d;
  logic [1:0]  winner_q, winner_d;
  logic [2:0]  win_line_q, win_line_d;
  logic        draw_q, draw_d;
  logic        err_q, err_d;

  logic [8:0]  mask;
  logic        p1_win, p2_win;
  logic [1:0]  line_owner;

  // Cell membership of each line, in the fixed evaluation order.
  function automatic logic [8:0] line_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    line_mask = 9'b000_000_111;  // cells 0,1,2
      3'd1:    line_mask = 9'b000_111_000;  // cells 3,4,5
      3'd2:    line_mask = 9'b111_000_000;  // cells 6,7,8
      3'd3:    line_mask = 9'b001_001_001;  // cells 0,3,6
      3'd4:    line_mask = 9'b010_010_010;  // cells 1,4,7
      3'd5:    line_mask = 9'b100_100_100;  // cells 2,5,8
      3'd6:    line_mask = 9'b100_010_001;  // cells 0,4,8
      default: line_mask = 9'b001_010_100;  // cells 2,4,6
    endcase
  endfunction

  assign mask       = line_mask(chk_q);
  assign p1_win     = ((p1_q & mask) == mask);
  assign p2_win     = ((p2_q & mask) == mask);
  assign line_owner = p1_win ? 2'b01 : (p2_win ? 2'b10 : 2'b00);

  // State and datapath registers; reset clears everything including the board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 4'd0;
      chk_q      <= 3'd0;
      p1_q       <= 9'd0;
      p2_q       <= 9'd0;
      winner_q   <= 2'b00;
      win_line_q <= 3'd0;
      draw_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      chk_q      <= chk_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
      draw_q     <= draw_d;
      err_q      <= err_d;
    end
  end

  // Next-state and result update logic.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    chk_d      = chk_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    winner_d   = winner_q;
    win_line_d = win_line_q;
    draw_d     = draw_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SCAN;
          sel_d      = 4'd0;
          chk_d      = 3'd0;
          winner_d   = 2'b00;
          win_line_d = 3'd0;
          draw_d     = 1'b0;
          err_d      = 1'b0;
        end
      end

      SCAN: begin
        // Unknown codes count as empty but flag the board as illegal.
        for (int i = 0; i < 9; i++) begin
          if (sel_q == 4'(i)) begin
            p1_d[i] = (cell_data == P1_CODE);
            p2_d[i] = (cell_data == P2_CODE);
          end
        end
        if ((cell_data != P1_CODE) && (cell_data != P2_CODE) &&
            (cell_data != 16'd0)) begin
          err_d = 1'b1;
        end
        if (sel_q == 4'd8) begin
          state_d = CHECK;
          sel_d   = 4'd0;
          chk_d   = 3'd0;
        end else begin
          sel_d = sel_q + 4'd1;
        end
      end

      CHECK: begin
        // First winning line sticks; a later win by the other player is illegal.
        if (line_owner != 2'b00) begin
          if (winner_q == 2'b00) begin
            winner_d   = line_owner;
            win_line_d = chk_q;
          end else if (winner_q != line_owner) begin
            err_d = 1'b1;
          end
        end
        if (chk_q == 3'd7) begin
          state_d = DONE;
          draw_d  = (winner_d == 2'b00) && ((p1_q | p2_q) == 9'h1FF) && !err_d;
        end else begin
          chk_d = chk_q + 3'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sel      = sel_q;
  assign busy     = (state_q == SCAN) || (state_q == CHECK);
  assign done     = (state_q == DONE);
  assign winner   = winner_q;
  assign win_line = win_line_q;
  assign draw     = draw_q;
  assign err      = err_q;

endmodule

// File: tb/tb_game_judge_ctrl.sv
// Testbench for game_judge_ctrl: fixed board table, randomized boards against
// a line-enumerating reference model, and hand sequences for timing/reset.
module tb_game_judge_ctrl;

  localparam logic [15:0] P1 = 16'd1;
  localparam logic [15:0] P2 = 16'd2;

  typedef logic [8:0][15:0] board_t;

  typedef struct {
    board_t     b;
    logic [1:0] w;
    logic [2:0] l;
    logic       d;
    logic       e;
  } vec_t;

  typedef struct packed {
    logic [1:0] w;
    logic [2:0] l;
    logic       d;
    logic       e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cell_data;
  logic [3:0]  sel;
  logic        busy;
  logic        done;
  logic [1:0]  winner;
  logic [2:0]  win_line;
  logic        draw;
  logic        err;

  logic [15:0] board [9];

  int checks = 0;
  int errors = 0;

  game_judge_ctrl #(.P1_CODE(P1), .P2_CODE(P2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cell_data(cell_data),
    .sel(sel), .busy(busy), .done(done), .winner(winner),
    .win_line(win_line), .draw(draw), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural 9:1 cell mux.
  always_comb begin
    cell_data = 16'd0;
    for (int i = 0; i < 9; i++)
      if (sel == 4'(i)) cell_data = board[i];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic board_t mkb(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    board_t b;
    b[0] = 16'(a0); b[1] = 16'(a1); b[2] = 16'(a2);
    b[3] = 16'(a3); b[4] = 16'(a4); b[5] = 16'(a5);
    b[6] = 16'(a6); b[7] = 16'(a7); b[8] = 16'(a8);
    return b;
  endfunction

  // Reference: classify cells, enumerate all lines, apply the judging rules.
  function automatic exp_t model(input board_t b);
    int   cls [9];
    int   lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                           '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    bit   illegal = 0;
    bit   won1 = 0, won2 = 0;
    int   first = -1, first_p = 0;
    bit   full = 1;
    exp_t r;
    for (int i = 0; i < 9; i++) begin
      if (b[i] == P1)          cls[i] = 1;
      else if (b[i] == P2)     cls[i] = 2;
      else begin
        cls[i] = 0;
        if (b[i] != 16'd0) illegal = 1;
      end
      if (cls[i] == 0) full = 0;
    end
    for (int l = 0; l < 8; l++) begin
      int a = cls[lines[l][0]];
      if (a != 0 && a == cls[lines[l][1]] && a == cls[lines[l][2]]) begin
        if (a == 1) won1 = 1; else won2 = 1;
        if (first < 0) begin first = l; first_p = a; end
      end
    end
    if (won1 && won2) illegal = 1;
    r.w = (first < 0) ? 2'b00 : 2'(first_p);
    r.l = (first < 0) ? 3'd0 : 3'(first);
    r.e = illegal;
    r.d = (first < 0) && full && !illegal;
    return r;
  endfunction

  // One judgement: starts, checks per-cycle sel/busy/done, optionally pulses
  // start in cycle inject_c, then compares held results with expectations.
  task automatic judge(input string tag, input board_t b, input int inject_c,
                       input exp_t ex);
    int done_cnt = 0;
    int done_c = -1;
    for (int i = 0; i < 9; i++) board[i] = b[i];
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      start = (c == inject_c);
      if (done) begin done_cnt++; done_c = c; end
      chk($sformatf("%s sel c%0d", tag, c), sel, (c >= 1 && c <= 9) ? c - 1 : 0);
      chk($sformatf("%s busy c%0d", tag, c), busy, (c <= 17) ? 1 : 0);
    end
    start = 1'b0;
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " done_cycle"}, done_c, 18);
    chk({tag, " winner"}, winner, ex.w);
    chk({tag, " win_line"}, win_line, ex.l);
    chk({tag, " draw"}, draw, ex.d);
    chk({tag, " err"}, err, ex.e);
  endtask

  vec_t vecs [7];

  initial begin
    exp_t   ex;
    board_t rb;
    int     bad;

    vecs[0] = '{mkb(1,1,1,2,2,0,0,0,0), 2'b01, 3'd0, 1'b0, 1'b0}; // row win
    vecs[1] = '{mkb(1,1,2,0,2,0,2,0,0), 2'b10, 3'd7, 1'b0, 1'b0}; // anti-diagonal
    vecs[2] = '{mkb(1,2,1,1,2,2,2,1,1), 2'b00, 3'd0, 1'b1, 1'b0}; // full draw
    vecs[3] = '{mkb(1,1,1,0,5,0,2,2,2), 2'b01, 3'd0, 1'b0, 1'b1}; // illegal
    vecs[4] = '{mkb(2,1,2,0,1,0,0,1,0), 2'b01, 3'd4, 1'b0, 1'b0}; // column 1
    vecs[5] = '{mkb(0,0,0,0,0,0,0,0,0), 2'b00, 3'd0, 1'b0, 1'b0}; // empty
    vecs[6] = '{mkb(1,1,1,2,2,1,2,1,2), 2'b01, 3'd0, 1'b0, 1'b0}; // full, won

    for (int i = 0; i < 9; i++) board[i] = 16'd0;
    start = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("reset sel", sel, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset winner", winner, 0);
    chk("reset win_line", win_line, 0);
    chk("reset draw", draw, 0);
    chk("reset err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle busy", busy, 0);

    // Table-driven boards.
    for (int i = 0; i < 7; i++) begin
      ex = '{w: vecs[i].w, l: vecs[i].l, d: vecs[i].d, e: vecs[i].e};
      judge($sformatf("vec%0d", i), vecs[i].b, 0, ex);
    end

    // Start pulsed during SCAN, CHECK and DONE: all ignored.
    judge("start_in_check", vecs[1].b, 12, '{w: 2'b10, l: 3'd7, d: 1'b0, e: 1'b0});
    judge("start_in_scan", vecs[2].b, 4, '{w: 2'b00, l: 3'd0, d: 1'b1, e: 1'b0});
    judge("start_in_done", vecs[0].b, 18, '{w: 2'b01, l: 3'd0, d: 1'b0, e: 1'b0});

    // Reset in cycle 5 of a judgement: outputs clear immediately, no done.
    for (int i = 0; i < 9; i++) board[i] = vecs[0].b[i];
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset sel", sel, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset winner", winner, 0);
    chk("midreset win_line", win_line, 0);
    chk("midreset draw", draw, 0);
    chk("midreset err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("midreset stays idle", bad, 0);

    // Reset in the middle of CHECK also aborts.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("checkreset busy", busy, 0);
    chk("checkreset winner", winner, 0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("checkreset stays idle", bad, 0);

    // Randomized boards against the reference model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 9; i++) begin
        int r = $urandom_range(0, 19);
        if (r < 6)       rb[i] = 16'd0;
        else if (r < 12) rb[i] = P1;
        else if (r < 18) rb[i] = P2;
        else             rb[i] = 16'd3 + 16'($urandom_range(0, 60000));
      end
      judge($sformatf("rand%0d", n), rb, 0, model(rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_judge_ctrl.md
GAME_JUDGE_CTRL -- requirements
Module: game_judge_ctrl

Interface
REQ-001 SHALL have parameter P1_CODE, default 16'd1, the 16-bit cell value meaning player 1 occupies the cell.
REQ-002 SHALL have parameter P2_CODE, default 16'd2, the 16-bit cell value meaning player 2 occupies the cell; 16'd0 means empty.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, request to judge the current board.
REQ-006 SHALL have port cell_data, input, 16 bits, the 9:1 cell-mux output for the cell addressed by sel.
REQ-007 SHALL have port sel, output, 4 bits, registered cell index 0..8 driving the cell-mux select.
REQ-008 SHALL have port busy, output, 1 bit, high while a judgement is in progress.
REQ-009 SHALL have port done, output, 1 bit, one-cycle pulse when results become valid.
REQ-010 SHALL have port winner, output, 2 bits: 00 none, 01 player 1, 10 player 2.
REQ-011 SHALL have port win_line, output, 3 bits, index of the winning line (valid when winner != 00).
REQ-012 SHALL have port draw, output, 1 bit, board full with no winner.
REQ-013 SHALL have port err, output, 1 bit, illegal board detected.

Function
REQ-014 SHALL implement states IDLE, SCAN, CHECK, DONE.
REQ-015 In IDLE, start=1 SHALL move to SCAN at the next edge, set sel=0, and clear winner, win_line, draw, err.
REQ-016 start SHALL be ignored in SCAN, CHECK and DONE.
REQ-017 In SCAN, in the cycle sel=k, the rising edge ending that cycle SHALL capture cell_data into internal board cell k, then increment sel.
REQ-018 A captured cell SHALL be classified as P1 if equal to P1_CODE, P2 if equal to P2_CODE, empty if 0; any other value is classified empty and sets err.
REQ-019 After capturing cell 8, the block SHALL enter CHECK with sel returned to 0; sel SHALL be 0 in IDLE, CHECK and DONE.
REQ-020 CHECK SHALL last exactly 8 cycles and evaluate one line per cycle in this order: 0:{0,1,2} 1:{3,4,5} 2:{6,7,8} 3:{0,3,6} 4:{1,4,7} 5:{2,5,8} 6:{0,4,8} 7:{2,4,6}.
REQ-021 A line SHALL win when all three of its cells hold the same non-empty player.
REQ-022 The first, lowest-index winning line SHALL set winner and win_line; later lines SHALL NOT overwrite them.
REQ-023 If lines are won by both players, err SHALL be set, and winner/win_line SHALL keep the lowest-index line.
REQ-024 On leaving CHECK, draw SHALL be set iff winner=00, all 9 cells are non-empty, and err=0.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 winner, win_line, draw and err SHALL hold their values from DONE until the next accepted start.
REQ-027 busy SHALL be 1 exactly in SCAN and CHECK.
REQ-028 Latency: with start accepted at edge 0, SCAN SHALL occupy cycles 1-9, CHECK cycles 10-17, and done SHALL be high in cycle 18.
REQ-029 No early exit SHALL be taken; the latency is fixed regardless of board contents.

Reset
REQ-030 rst_n=0 SHALL, asynchronously, force state IDLE, sel=0, busy=0, done=0, winner=00, win_line=0, draw=0, err=0, and clear all board cells to empty.
REQ-031 Reset asserted mid-SCAN or mid-CHECK SHALL abort without emitting done; after release the block SHALL wait in IDLE for start.

Verification
REQ-032 Row win: cells 0,1,2=1, cells 3,4=2, rest 0, start -> sel steps 0..8 in cycles 1-9, done in cycle 18, winner=01, win_line=0, draw=0, err=0.
REQ-033 Diagonal win: cells 2,4,6=2, cells 0,1=1, rest 0 -> winner=10, win_line=7.
REQ-034 Full-board draw: cells 0..8 = 1,2,1,1,2,2,2,1,1 -> winner=00, draw=1, err=0.
REQ-035 Illegal board: cells 0,1,2=1, cells 6,7,8=2, cell 4=16'd5 -> winner=01, win_line=0, err=1, draw=0.
REQ-036 Start is pulsed again during CHECK -> ignored, a single done pulse is produced; rst_n is then pulsed low in cycle 5 of a new judgement -> all outputs read 0 immediately and no done is produced.
